l1_l2_arbiter: RTL and testbench

- Sits directly downstream of the L1 instruction and L1 data cache controllers, between their `read_L1_L2`/`write_L1_L2`/`ready_L2_L1` handshakes and the single L2 request port.
- Arbitrates block-level refill reads and write-backs from both L1s, round-robin.
- Registers and holds the winning request toward L2.
- Returns the one-cycle ready pulse and the refill data to the requester that was served.

---
 rtl/l1_l2_arbiter.sv | 122 ++++++++++++
 tb/tb_l1_l2_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter merging L1-I and L1-D block requests onto one L2 port.
// One transaction is outstanding at a time; the winner's request is registered and held until L2 answers.
module l1_l2_arbiter #(
  parameter int ADDR_W  = 58,
  parameter int BLOCK_W = 512
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               read_I_L2,
  input  logic [ADDR_W-1:0]  addr_I,
  output logic               ready_L2_I,
  output logic [BLOCK_W-1:0] rdata_L2_I,
  input  logic               read_D_L2,
  input  logic               write_D_L2,
  input  logic [ADDR_W-1:0]  addr_D,
  input  logic [BLOCK_W-1:0] wdata_D,
  output logic               ready_L2_D,
  output logic [BLOCK_W-1:0] rdata_L2_D,
  output logic               read_L2,
  output logic               write_L2,
  output logic [ADDR_W-1:0]  addr_L2,
  output logic [BLOCK_W-1:0] wdata_L2,
  input  logic               ready_L2,
  input  logic [BLOCK_W-1:0] rdata_L2
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t               state, state_nxt;
  logic                 last_grant_d, last_grant_d_nxt;
  logic                 req_i, req_d, grant_i;
  logic                 read_nxt, write_nxt, ready_i_nxt, ready_d_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [BLOCK_W-1:0]   wdata_nxt, rdata_i_nxt, rdata_d_nxt;

  assign req_i   = read_I_L2;
  assign req_d   = read_D_L2 | write_D_L2;
  // I wins when alone, or on a tie when D had the previous tie.
  assign grant_i = req_i & (~req_d | last_grant_d);

  always_comb begin
    state_nxt        = state;
    last_grant_d_nxt = last_grant_d;
    read_nxt         = read_L2;
    write_nxt        = write_L2;
    addr_nxt         = addr_L2;
    wdata_nxt        = wdata_L2;
    ready_i_nxt      = 1'b0;
    ready_d_nxt      = 1'b0;
    rdata_i_nxt      = rdata_L2_I;
    rdata_d_nxt      = rdata_L2_D;
    case (state)
      IDLE: begin
        if (req_i && req_d) last_grant_d_nxt = ~grant_i;
        if (grant_i) begin
          state_nxt = BUSY_I;
          read_nxt  = 1'b1;
          write_nxt = 1'b0;
          addr_nxt  = addr_I;
        end else if (req_d) begin
          state_nxt = BUSY_D;
          addr_nxt  = addr_D;
          // Dirty victim goes out first; the refill is re-requested afterwards.
          if (write_D_L2) begin
            read_nxt  = 1'b0;
            write_nxt = 1'b1;
            wdata_nxt = wdata_D;
          end else begin
            read_nxt  = 1'b1;
            write_nxt = 1'b0;
          end
        end
      end
      BUSY_I: begin
        if (ready_L2) begin
          state_nxt   = DONE;
          read_nxt    = 1'b0;
          write_nxt   = 1'b0;
          ready_i_nxt = 1'b1;
          rdata_i_nxt = rdata_L2;
        end
      end
      BUSY_D: begin
        if (ready_L2) begin
          state_nxt   = DONE;
          read_nxt    = 1'b0;
          write_nxt   = 1'b0;
          ready_d_nxt = 1'b1;
          if (read_L2) rdata_d_nxt = rdata_L2;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      read_L2      <= 1'b0;
      write_L2     <= 1'b0;
      addr_L2      <= '0;
      wdata_L2     <= '0;
      ready_L2_I   <= 1'b0;
      ready_L2_D   <= 1'b0;
      rdata_L2_I   <= '0;
      rdata_L2_D   <= '0;
    end else begin
      state        <= state_nxt;
      last_grant_d <= last_grant_d_nxt;
      read_L2      <= read_nxt;
      write_L2     <= write_nxt;
      addr_L2      <= addr_nxt;
      wdata_L2     <= wdata_nxt;
      ready_L2_I   <= ready_i_nxt;
      ready_L2_D   <= ready_d_nxt;
      rdata_L2_I   <= rdata_i_nxt;
      rdata_L2_D   <= rdata_d_nxt;
    end
  end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: arbitration order, handshakes, holds, stray ready and reset.
module tb_l1_l2_arbiter;
  localparam int AW = 58;
  localparam int BW = 512;

  logic          clk = 1'b0;
  logic          nrst;
  logic          read_I_L2, read_D_L2, write_D_L2, ready_L2;
  logic [AW-1:0] addr_I, addr_D;
  logic [BW-1:0] wdata_D, rdata_L2;
  logic          ready_L2_I, ready_L2_D, read_L2, write_L2;
  logic [AW-1:0] addr_L2;
  logic [BW-1:0] rdata_L2_I, rdata_L2_D, wdata_L2;

  int n_tests = 0;
  int n_fail  = 0;

  l1_l2_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clk(clk), .nrst(nrst),
    .read_I_L2(read_I_L2), .addr_I(addr_I), .ready_L2_I(ready_L2_I), .rdata_L2_I(rdata_L2_I),
    .read_D_L2(read_D_L2), .write_D_L2(write_D_L2), .addr_D(addr_D), .wdata_D(wdata_D),
    .ready_L2_D(ready_L2_D), .rdata_L2_D(rdata_L2_D),
    .read_L2(read_L2), .write_L2(write_L2), .addr_L2(addr_L2), .wdata_L2(wdata_L2),
    .ready_L2(ready_L2), .rdata_L2(rdata_L2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first busy cycle; checks the held request, then answers after lat cycles.
  // Returns in the cycle where the ready pulse should be visible.
  task automatic serve(input int lat, input logic [BW-1:0] d,
                       input logic er, input logic ew, input logic [AW-1:0] ea);
    for (int i = 0; i <= lat; i++) begin
      chk("busy_rd", read_L2, er);
      chk("busy_wr", write_L2, ew);
      chk("busy_addr", addr_L2, ea);
      if (i < lat) tick();
    end
    ready_L2 = 1'b1;
    rdata_L2 = d;
    tick();
    ready_L2 = 1'b0;
    rdata_L2 = '0;
    chk("done_rd", read_L2, 1'b0);
    chk("done_wr", write_L2, 1'b0);
  endtask

  logic [BW-1:0] pat_a5;
  localparam logic [BW-1:0] DI2 = 512'h1111;
  localparam logic [BW-1:0] DD2 = 512'h2222;
  localparam logic [BW-1:0] DD3 = 512'h3333;
  localparam logic [BW-1:0] DI3 = 512'h4444;

  initial begin
    pat_a5 = {64{8'hA5}};
    nrst = 1'b0; read_I_L2 = 1'b0; read_D_L2 = 1'b0; write_D_L2 = 1'b0; ready_L2 = 1'b0;
    addr_I = '0; addr_D = '0; wdata_D = '0; rdata_L2 = '0;
    tick(); tick();
    chk("rst_rd", read_L2, 1'b0);
    chk("rst_wr", write_L2, 1'b0);
    chk("rst_addr", addr_L2, '0);
    chk("rst_rdy_i", ready_L2_I, 1'b0);
    chk("rst_rdy_d", ready_L2_D, 1'b0);

    // 1: single I read, request at cycle 0, L2 ready at cycle 5
    nrst = 1'b1;
    read_I_L2 = 1'b1; addr_I = 58'h0123_4567_89AB_CDE;
    chk("t1_c0_rd", read_L2, 1'b0);
    tick();
    serve(4, pat_a5, 1'b1, 1'b0, 58'h0123_4567_89AB_CDE);
    chk("t1_rdy_i", ready_L2_I, 1'b1);
    chk("t1_rdata_i", rdata_L2_I, pat_a5);
    chk("t1_rdy_d", ready_L2_D, 1'b0);
    read_I_L2 = 1'b0;
    tick();
    chk("t1_rdy_i_pulse", ready_L2_I, 1'b0);
    chk("t1_rdata_hold", rdata_L2_I, pat_a5);

    // 2: tie -> I first, then D; the next tie goes to D
    read_I_L2 = 1'b1; addr_I = 58'h100;
    read_D_L2 = 1'b1; addr_D = 58'h200;
    tick();
    serve(3, DI2, 1'b1, 1'b0, 58'h100);
    chk("t2_rdy_i", ready_L2_I, 1'b1);
    chk("t2_rdy_d0", ready_L2_D, 1'b0);
    chk("t2_rdata_i", rdata_L2_I, DI2);
    read_I_L2 = 1'b0;
    tick();
    chk("t2_idle_rd", read_L2, 1'b0);
    tick();
    serve(3, DD2, 1'b1, 1'b0, 58'h200);
    chk("t2_rdy_d", ready_L2_D, 1'b1);
    chk("t2_rdy_i0", ready_L2_I, 1'b0);
    chk("t2_rdata_d", rdata_L2_D, DD2);
    read_D_L2 = 1'b0;
    tick();
    read_I_L2 = 1'b1; read_D_L2 = 1'b1;
    tick();
    serve(1, DD3, 1'b1, 1'b0, 58'h200);
    chk("t2_rr_rdy_d", ready_L2_D, 1'b1);
    chk("t2_rr_rdata_d", rdata_L2_D, DD3);
    read_D_L2 = 1'b0;
    tick(); tick();
    serve(1, DI3, 1'b1, 1'b0, 58'h100);
    chk("t2_rr_rdy_i", ready_L2_I, 1'b1);
    chk("t2_rr_rdata_i", rdata_L2_I, DI3);
    read_I_L2 = 1'b0;
    tick();

    // 3: write-back precedes refill
    write_D_L2 = 1'b1; read_D_L2 = 1'b1; addr_D = 58'h3F; wdata_D = 512'h1234;
    tick();
    chk("t3_wdata", wdata_L2, 512'h1234);
    serve(2, 512'hBEEF, 1'b0, 1'b1, 58'h3F);
    chk("t3_wb_rdy_d", ready_L2_D, 1'b1);
    chk("t3_wb_nocap", rdata_L2_D, DD3);
    write_D_L2 = 1'b0;
    tick(); tick();
    chk("t3_wdata_keep", wdata_L2, 512'h1234);
    serve(1, 512'hC0DE, 1'b1, 1'b0, 58'h3F);
    chk("t3_rf_rdy_d", ready_L2_D, 1'b1);
    chk("t3_rf_rdata_d", rdata_L2_D, 512'hC0DE);
    read_D_L2 = 1'b0;
    tick();

    // 4: stray ready in IDLE is ignored
    ready_L2 = 1'b1; rdata_L2 = '1;
    tick();
    ready_L2 = 1'b0; rdata_L2 = '0;
    chk("t4_rdy_i", ready_L2_I, 1'b0);
    chk("t4_rdy_d", ready_L2_D, 1'b0);
    chk("t4_rdata_i", rdata_L2_I, DI3);
    chk("t4_rdata_d", rdata_L2_D, 512'hC0DE);
    read_I_L2 = 1'b1;
    tick();
    serve(1, 512'h77, 1'b1, 1'b0, 58'h100);
    chk("t4_after_rdy_i", ready_L2_I, 1'b1);
    read_I_L2 = 1'b0;
    tick();

    // 5: reset while a write-back is in flight
    write_D_L2 = 1'b1; addr_D = 58'h55; wdata_D = 512'h9;
    tick();
    chk("t5_wr", write_L2, 1'b1);
    nrst = 1'b0; read_I_L2 = 1'b1; addr_I = 58'h66;
    tick();
    nrst = 1'b1;
    chk("t5_rd0", read_L2, 1'b0);
    chk("t5_wr0", write_L2, 1'b0);
    chk("t5_addr0", addr_L2, '0);
    chk("t5_wdata0", wdata_L2, '0);
    chk("t5_rdy_i0", ready_L2_I, 1'b0);
    chk("t5_rdy_d0", ready_L2_D, 1'b0);
    chk("t5_rdata_i0", rdata_L2_I, '0);
    chk("t5_rdata_d0", rdata_L2_D, '0);
    tick();
    serve(1, 512'h88, 1'b1, 1'b0, 58'h66);
    chk("t5_rdy_i", ready_L2_I, 1'b1);
    read_I_L2 = 1'b0;
    tick(); tick();
    chk("t5_wdata", wdata_L2, 512'h9);
    serve(1, 512'hDEAD, 1'b0, 1'b1, 58'h55);
    chk("t5_rdy_d", ready_L2_D, 1'b1);
    chk("t5_rdata_d", rdata_L2_D, '0);
    write_D_L2 = 1'b0;
    tick();

    // 6: requester drops mid-transaction
    read_I_L2 = 1'b1; addr_I = 58'hAA;
    tick();
    read_I_L2 = 1'b0;
    serve(2, 512'h99, 1'b1, 1'b0, 58'hAA);
    chk("t6_rdy_i", ready_L2_I, 1'b1);
    chk("t6_rdata_i", rdata_L2_I, 512'h99);
    tick();
    chk("t6_rdy_i_once", ready_L2_I, 1'b0);
    chk("t6_done_rd", read_L2, 1'b0);
    tick();
    chk("t6_idle_rd", read_L2, 1'b0);
    chk("t6_idle_rdy", ready_L2_I, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
